// File: rtl/tff_pkg.sv
// ============================================================================
// tff_pkg : shared constants and types for the toggle flip-flop family
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package tff_pkg;

  localparam int unsigned TFF_MAX_WIDTH = 64;

  // Per-bit reset value used when a client does not override RESET_VAL.
  localparam logic TFF_RESET_DEFAULT_BIT = 1'b0;

  typedef logic [TFF_MAX_WIDTH-1:0] tff_vec_t;

endpackage : tff_pkg

`default_nettype wire

// File: rtl/tff_cell.sv
// ============================================================================
// tff_cell : single-bit toggle flop with asynchronous active-low reset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tff_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // An unknown t propagates to q as X, which is the intended simulation behaviour.
  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : tff_cell

`default_nettype wire

// File: rtl/tff.sv
// ============================================================================
// tff : vector of independent toggle flip-flops, one tff_cell per bit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tff
  import tff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{TFF_RESET_DEFAULT_BIT}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  if ((WIDTH < 1) || (WIDTH > TFF_MAX_WIDTH)) begin : g_width_check
    $error("tff: WIDTH out of range 1..%0d", TFF_MAX_WIDTH);
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    tff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rstn (rstn),
      .t    (t[i]),
      .q    (q[i])
    );
  end

`ifndef SYNTHESIS
  // Armed one edge after reset release so the hold check never compares against pre-reset state.
  logic armed_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  a_reset_val : assert property (@(negedge clk) !rstn |-> (q == RESET_VAL))
    else $error("tff: q differs from RESET_VAL while in reset");

  a_t_known : assert property (@(posedge clk) disable iff (!rstn) !$isunknown(t))
    else $error("tff: unknown t at active edge");

  a_hold : assert property (@(posedge clk) disable iff (!rstn)
                            armed_q |-> (((q ^ $past(q)) & ~$past(t)) == '0))
    else $error("tff: bit changed without a toggle request");
`endif

endmodule : tff

`default_nettype wire

// File: tb/tb_tff.sv
// ============================================================================
// tb_tff : scoreboard bench for tff, default 1-bit and 4-bit (RESET_VAL=1010)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_tff;

  localparam logic [3:0] RST4 = 4'b1010;

  typedef struct packed {
    logic       q1;
    logic [3:0] q4;
  } exp_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic       t1   = 1'b0;
  logic [3:0] t4   = 4'b0000;
  logic       q1;
  logic [3:0] q4;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Toggle counts since the last reset; expected q is reset value xor count parity.
  int cnt1;
  int cnt4 [4];

  tff u_dut1 (
    .clk  (clk),
    .rstn (rstn),
    .t    (t1),
    .q    (q1)
  );

  tff #(
    .WIDTH     (4),
    .RESET_VAL (RST4)
  ) u_dut4 (
    .clk  (clk),
    .rstn (rstn),
    .t    (t4),
    .q    (q4)
  );

  initial begin
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.q1 = cnt1[0];
    for (int i = 0; i < 4; i++) begin
      e.q4[i] = RST4[i] ^ cnt4[i][0];
    end
    return e;
  endfunction

  // Drives one clock edge worth of stimulus at the falling edge and queues the expected result.
  task automatic cycle(input logic rst, input logic t1v, input logic [3:0] t4v, input bit pulse);
    @(negedge clk);
    rstn = rst;
    if (!rst) begin
      #1;
      check("async_reset_q1", {3'b000, q1}, 4'b0000);
      check("async_reset_q4", q4, RST4);
    end
    if (pulse) begin
      t1 = 1'b0;
      t4 = 4'b0000;
      #1;
      t1 = 1'b1;
      t4 = 4'b1111;
      #2;
    end
    t1 = t1v;
    t4 = t4v;
    if (!rst) begin
      cnt1 = 0;
      for (int i = 0; i < 4; i++) cnt4[i] = 0;
    end else begin
      cnt1 += int'(t1v);
      for (int i = 0; i < 4; i++) cnt4[i] += int'(t4v[i]);
    end
    exp_q.push_back(model_expect());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("edge_q1", {3'b000, q1}, {3'b000, e.q1});
        check("edge_q4", q4, e.q4);
      end
    end
  end

  initial begin : stimulus
    cnt1 = 0;
    for (int i = 0; i < 4; i++) cnt4[i] = 0;
    rstn = 1'b0;
    #1;
    check("reset_q1", {3'b000, q1}, 4'b0000);
    check("reset_q4", q4, RST4);
    #8;
    check("reset_hold_q1", {3'b000, q1}, 4'b0000);
    check("reset_hold_q4", q4, RST4);
    #1;
    rstn = 1'b1;

    cycle(1'b1, 1'b1, 4'b0110, 1'b0);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    repeat (8) cycle(1'b1, 1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 4'b1111, 1'b0);
    cycle(1'b0, 1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);

    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
            1'($urandom),
            4'($urandom),
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_tff

`default_nettype wire
